// File: rtl/pslip_gnt_arb.sv
// pslip_gnt_arb -- single-iteration iSLIP grant arbiter.
//
// Picks one requester per req_valid strobe, round-robin from ptr, and holds
// the one-hot grant until the downstream accept decision arrives. ptr only
// advances past the granted port when the grant is accepted.
//
// Optional feature: define ARB_TIMEOUT_EN to abandon a grant that has seen no
// accept decision after TO_CYCLES cycles in WAIT (pulses timeout). Without the
// macro, WAIT persists until accept_valid and timeout is tied low.
//
// Ports:
//   clk          clock, rising edge
//   reset        synchronous, active-low reset
//   req          per-port request vector (N bits)
//   req_valid    strobe qualifying req
//   accept_valid strobe carrying the accept decision for the outstanding grant
//   accept       1 = grant accepted, 0 = grant rejected
//   gnt          one-hot grant, zero when no grant is outstanding
//   gnt_valid    one-cycle strobe marking a new grant
//   ptr          round-robin grant pointer
//   busy         high whenever not IDLE
//   timeout      one-cycle strobe on accept timeout (0 without ARB_TIMEOUT_EN)
module pslip_gnt_arb #(
  parameter int unsigned N         = 4,
  parameter int unsigned TO_CYCLES = 8,
  localparam int unsigned PW       = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req,
  input  logic          req_valid,
  input  logic          accept_valid,
  input  logic          accept,
  output logic [N-1:0]  gnt,
  output logic          gnt_valid,
  output logic [PW-1:0] ptr,
  output logic          busy,
  output logic          timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t        state_q;
  logic [N-1:0]  gnt_q;
  logic          gnt_valid_q;
  logic [PW-1:0] ptr_q;
  logic [PW-1:0] gidx_q;

  logic [N-1:0]  pick_oh;
  logic [PW-1:0] pick_idx;
  logic [PW-1:0] scan_idx;
  logic          found;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CW = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;
  logic [CW-1:0] cnt_q;
  logic          timeout_q;
`endif

  // Round-robin scan starting at ptr; N is a power of two so the PW-bit
  // addition wraps modulo N on its own.
  always_comb begin
    pick_oh  = '0;
    pick_idx = '0;
    scan_idx = '0;
    found    = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      scan_idx = ptr_q + PW'(k);
      if (!found && req[scan_idx]) begin
        found             = 1'b1;
        pick_idx          = scan_idx;
        pick_oh[scan_idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      ptr_q       <= '0;
      gidx_q      <= '0;
`ifdef ARB_TIMEOUT_EN
      cnt_q       <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      gnt_valid_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      timeout_q   <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (req_valid && found) begin
            state_q     <= GRANT;
            gnt_q       <= pick_oh;
            gidx_q      <= pick_idx;
            gnt_valid_q <= 1'b1;
          end else begin
            gnt_q <= '0;
          end
        end
        GRANT: begin
          // An accept landing in the grant cycle itself completes the
          // transaction without ever entering WAIT.
          if (accept_valid) begin
            if (accept) ptr_q <= gidx_q + PW'(1);
            state_q <= IDLE;
            gnt_q   <= '0;
          end else begin
            state_q <= WAIT;
`ifdef ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
          end
        end
        WAIT: begin
          if (accept_valid) begin
            if (accept) ptr_q <= gidx_q + PW'(1);
            state_q <= IDLE;
            gnt_q   <= '0;
`ifdef ARB_TIMEOUT_EN
          end else if (cnt_q == CW'(TO_CYCLES - 1)) begin
            // Accept is checked first, so it wins over a same-cycle expiry.
            state_q   <= IDLE;
            gnt_q     <= '0;
            timeout_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
`endif
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= '0;
        end
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;
  assign ptr       = ptr_q;
  assign busy      = (state_q != IDLE);

`ifdef ARB_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pslip_gnt_arb.sv
module tb_pslip_gnt_arb;

  localparam int unsigned N  = 4;
  localparam int unsigned TO = 8;

  logic         clk;
  logic         reset;
  logic [N-1:0] req;
  logic         req_valid;
  logic         accept_valid;
  logic         accept;
  logic [N-1:0] gnt;
  logic         gnt_valid;
  logic [1:0]   ptr;
  logic         busy;
  logic         timeout;

  int checks = 0;
  int errors = 0;

  logic [N-1:0] exp_q[$];
  logic [N-1:0] exp_g;
  logic [1:0]   m_ptr;

  pslip_gnt_arb #(.N(N), .TO_CYCLES(TO)) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .req_valid    (req_valid),
    .accept_valid (accept_valid),
    .accept       (accept),
    .gnt          (gnt),
    .gnt_valid    (gnt_valid),
    .ptr          (ptr),
    .busy         (busy),
    .timeout      (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference round-robin choice: first set bit at p, p+1, ... mod N.
  function automatic logic [N-1:0] rr_pick(input logic [N-1:0] r, input int p);
    logic [N-1:0] oh;
    oh = '0;
    for (int k = 0; k < int'(N); k++) begin
      if (r[(p + k) % N]) begin
        oh[(p + k) % N] = 1'b1;
        return oh;
      end
    end
    return oh;
  endfunction

  function automatic logic [1:0] oh_idx(input logic [N-1:0] oh);
    for (int i = 0; i < int'(N); i++) if (oh[i]) return 2'(i);
    return 2'd0;
  endfunction

  // Drive a request in IDLE and push the model's expected grant.
  task automatic issue(input logic [N-1:0] r);
    req       = r;
    req_valid = 1'b1;
    exp_q.push_back(rr_pick(r, int'(m_ptr)));
    tick();
    req_valid = 1'b0;
    req       = '0;
  endtask

  task automatic pop_exp();
    if (exp_q.size() == 0) exp_g = '0;
    else exp_g = exp_q.pop_front();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    checks++;
    if ({gnt, gnt_valid, ptr, busy, timeout} !== 9'b0) begin
      errors++;
      $display("FAIL reset_state: gnt=%b gv=%b ptr=%0d busy=%b to=%b, required all 0",
               gnt, gnt_valid, ptr, busy, timeout);
    end
    reset = 1'b1;
    m_ptr = 2'd0;
  endtask

  task automatic test_basic();
    issue(4'b1010);
    pop_exp();
    checks++;
    if (gnt_valid !== 1'b1 || gnt !== exp_g || exp_g !== 4'b0010) begin
      errors++;
      $display("FAIL basic_grant: gv=%b gnt=%b, required gv=1 gnt=%b", gnt_valid, gnt, exp_g);
    end
    tick();
    checks++;
    if (gnt_valid !== 1'b0 || gnt !== 4'b0010 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_wait_hold: gv=%b gnt=%b busy=%b, required 0 0010 1", gnt_valid, gnt, busy);
    end
    accept_valid = 1'b1; accept = 1'b1;
    tick();
    accept_valid = 1'b0; accept = 1'b0;
    m_ptr = oh_idx(exp_g) + 2'd1;
    checks++;
    if (ptr !== 2'd2 || ptr !== m_ptr || busy !== 1'b0 || gnt !== 4'b0) begin
      errors++;
      $display("FAIL basic_accept: ptr=%0d busy=%b gnt=%b, required ptr=2 busy=0 gnt=0", ptr, busy, gnt);
    end
  endtask

  task automatic test_wrap_reject();
    issue(4'b0011);
    pop_exp();
    checks++;
    if (gnt_valid !== 1'b1 || gnt !== exp_g || exp_g !== 4'b0001) begin
      errors++;
      $display("FAIL wrap_grant: gv=%b gnt=%b, required gv=1 gnt=0001", gnt_valid, gnt);
    end
    tick();
    accept_valid = 1'b1; accept = 1'b0;
    tick();
    accept_valid = 1'b0;
    checks++;
    if (ptr !== 2'd2 || busy !== 1'b0 || gnt !== 4'b0) begin
      errors++;
      $display("FAIL reject_ptr: ptr=%0d busy=%b gnt=%b, required ptr=2 busy=0 gnt=0", ptr, busy, gnt);
    end
  endtask

  task automatic test_grant_cycle_accept();
    // ptr 2 -> 3 via an accepted grant of port 2
    issue(4'b0100);
    pop_exp();
    accept_valid = 1'b1; accept = 1'b1;
    tick();
    accept_valid = 1'b0; accept = 1'b0;
    m_ptr = oh_idx(exp_g) + 2'd1;
    checks++;
    if (ptr !== 2'd3 || ptr !== m_ptr) begin
      errors++;
      $display("FAIL ptr_to_3: ptr=%0d, required 3", ptr);
    end
    issue(4'b1000);
    pop_exp();
    checks++;
    if (gnt_valid !== 1'b1 || gnt !== exp_g || exp_g !== 4'b1000) begin
      errors++;
      $display("FAIL grant_cycle_gnt: gv=%b gnt=%b, required 1 1000", gnt_valid, gnt);
    end
    accept_valid = 1'b1; accept = 1'b1;
    tick();
    accept_valid = 1'b0; accept = 1'b0;
    m_ptr = oh_idx(exp_g) + 2'd1;
    checks++;
    if (ptr !== 2'd0 || busy !== 1'b0 || gnt !== 4'b0) begin
      errors++;
      $display("FAIL ptr_wrap_idle: ptr=%0d busy=%b gnt=%b, required 0 0 0", ptr, busy, gnt);
    end
  endtask

  task automatic test_no_req_and_lost();
    req = '0; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    checks++;
    if (gnt_valid !== 1'b0 || busy !== 1'b0 || gnt !== 4'b0) begin
      errors++;
      $display("FAIL zero_req: gv=%b busy=%b gnt=%b, required 0 0 0", gnt_valid, busy, gnt);
    end
    issue(4'b0001);
    pop_exp();
    checks++;
    if (gnt !== exp_g || gnt_valid !== 1'b1) begin
      errors++;
      $display("FAIL lost_setup: gnt=%b gv=%b, required %b 1", gnt, gnt_valid, exp_g);
    end
    tick();
    req = 4'b1000; req_valid = 1'b1;
    tick();
    req = '0; req_valid = 1'b0;
    checks++;
    if (gnt !== 4'b0001 || gnt_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL req_in_wait: gnt=%b gv=%b busy=%b, required 0001 0 1", gnt, gnt_valid, busy);
    end
    tick();
    checks++;
    if (gnt_valid !== 1'b0 || gnt !== 4'b0001) begin
      errors++;
      $display("FAIL no_second_gv: gnt=%b gv=%b, required 0001 0", gnt, gnt_valid);
    end
    accept_valid = 1'b1; accept = 1'b0;
    tick();
    accept_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || ptr !== m_ptr) begin
      errors++;
      $display("FAIL lost_clear: busy=%b ptr=%0d, required 0 %0d", busy, ptr, m_ptr);
    end
  endtask

  task automatic test_timeout();
    int bad;
    issue(4'b0010);
    pop_exp();
    bad = 0;
`ifdef ARB_TIMEOUT_EN
    for (int c = 0; c < int'(TO); c++) begin
      tick();
      if (busy !== 1'b1 || timeout !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL timeout_early: %0d WAIT cycles wrong, required 0", bad);
    end
    tick();
    checks++;
    if (timeout !== 1'b1 || busy !== 1'b0 || gnt !== 4'b0 || ptr !== m_ptr) begin
      errors++;
      $display("FAIL timeout_pulse: to=%b busy=%b gnt=%b ptr=%0d, required 1 0 0 %0d",
               timeout, busy, gnt, ptr, m_ptr);
    end
    tick();
    checks++;
    if (timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_width: to=%b, required 0", timeout);
    end
`else
    for (int c = 0; c < 100; c++) begin
      tick();
      if (busy !== 1'b1 || timeout !== 1'b0 || gnt !== exp_g) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL wait_persist: %0d cycles left WAIT, required 0", bad);
    end
    accept_valid = 1'b1; accept = 1'b0;
    tick();
    accept_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || ptr !== m_ptr) begin
      errors++;
      $display("FAIL wait_release: busy=%b ptr=%0d, required 0 %0d", busy, ptr, m_ptr);
    end
`endif
  endtask

  task automatic test_reset_in_wait();
    // bring ptr to 1
    issue(4'b0001);
    pop_exp();
    accept_valid = 1'b1; accept = 1'b1;
    tick();
    accept_valid = 1'b0; accept = 1'b0;
    m_ptr = oh_idx(exp_g) + 2'd1;
    checks++;
    if (ptr !== 2'd1) begin
      errors++;
      $display("FAIL ptr_to_1: ptr=%0d, required 1", ptr);
    end
    issue(4'b0100);
    pop_exp();
    tick();
    reset = 1'b0; accept_valid = 1'b1; accept = 1'b1;
    tick();
    reset = 1'b1; accept_valid = 1'b0; accept = 1'b0;
    m_ptr = 2'd0;
    checks++;
    if (gnt !== 4'b0 || gnt_valid !== 1'b0 || ptr !== 2'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_wait: gnt=%b gv=%b ptr=%0d busy=%b, required 0 0 0 0",
               gnt, gnt_valid, ptr, busy);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] r;
    int w;
    logic a;
    for (int it = 0; it < 30; it++) begin
      r = N'($urandom_range(1, (1 << N) - 1));
      w = int'($urandom_range(0, 3));
      a = 1'($urandom_range(0, 1));
      issue(r);
      pop_exp();
      checks++;
      if (gnt_valid !== 1'b1 || gnt !== exp_g) begin
        errors++;
        $display("FAIL rand_grant[%0d]: req=%b gnt=%b gv=%b, required %b 1", it, r, gnt, gnt_valid, exp_g);
      end
      for (int c = 0; c < w; c++) tick();
      accept_valid = 1'b1; accept = a;
      tick();
      accept_valid = 1'b0; accept = 1'b0;
      if (a) m_ptr = oh_idx(exp_g) + 2'd1;
      checks++;
      if (ptr !== m_ptr || busy !== 1'b0 || gnt !== 4'b0) begin
        errors++;
        $display("FAIL rand_done[%0d]: ptr=%0d busy=%b gnt=%b, required %0d 0 0", it, ptr, busy, gnt, m_ptr);
      end
    end
  endtask

  initial begin
    reset        = 1'b0;
    req          = '0;
    req_valid    = 1'b0;
    accept_valid = 1'b0;
    accept       = 1'b0;
    m_ptr        = 2'd0;
    exp_g        = '0;
    test_reset();
    test_basic();
    test_wrap_reject();
    test_grant_cycle_accept();
    test_no_req_and_lost();
    test_timeout();
    test_reset_in_wait();
    test_random();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
